pipe_elastic: RTL and testbench
===============================

Name: pipe_elastic

Overview:
- Parametrised elastic pipeline: DEPTH register stages of DW-bit data with valid/ready handshake on both sides. It is the clocked, stallable successor to our single-phase latch primitives.
- Used for retiming long paths between blocks where either side can stall.
- Bubbles collapse: an empty stage always accepts, even when the output is stalled.
- Full throughput of 1 word/clk when not back-pressured.

Parameters:
- DW, 1: data width in bits (>=1).
- DEPTH, 2: number of register stages (>=1); equals the latency and the storage capacity in words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all stage valids; has the same effect on valids as reset.
- in_valid  in  1  upstream word present.
- in_data  in  DW  upstream word.
- in_ready  out  1  pipe accepts in_data this cycle.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  DW  oldest stored word (stage DEPTH-1).
- out_ready  in  1  downstream accepts this cycle.
- count  out  $clog2(DEPTH+1)  present only with PIPE_ELASTIC_COUNT_EN: number of stored words.

Behaviour:
- State: v[i] and d[i] for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives out_valid = v[DEPTH-1] and out_data = d[DEPTH-1].
- Advance chain (combinational):
  - adv[DEPTH-1] = out_ready | !v[DEPTH-1].
  - adv[i] = adv[i+1] | !v[i].
  - in_ready = adv[0] & !flush & !reset.
- Per clock, for each stage i with adv[i]=1: v[i] <= source valid and d[i] <= source data. The source is stage i-1, or in_valid/in_data for i=0. Stages with adv[i]=0 hold.
- d[i] loads only when the source valid is 1. Data registers are not reset; their contents are don't-care while v[i]=0.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_valid and out_data stay stable while out_valid=1 and out_ready=0.
- Latency: a word accepted at edge N appears on out_valid after edge N+DEPTH-1 when no stall occurs, i.e. DEPTH register stages.
- Throughput: with out_ready held at 1, one word per cycle in and out, and no bubbles are inserted.
- Bubble collapse: with out_ready=0, new words keep filling empty stages until all DEPTH stages are valid. in_ready then drops to 0 in the same cycle.
- Full with out_ready=1: in_ready=1 and simultaneous accept and emit occur in the same cycle; occupancy is unchanged.
- Empty: out_valid=0. out_ready is ignored.
- Reset values: all v[i]=0, so out_valid=0 and in_ready=0 while reset=1. count=0. out_data is undefined until the first word arrives.
- flush=1 (or reset=1):
  - All v[i] <= 0 at the edge.
  - in_data offered during that cycle is not accepted, since in_ready=0.
  - An output transfer in the flush cycle still counts as a completed downstream transfer.
- Reset or flush mid-stall discards every stored word. There is no partial drain.
- No internal combinational path from in_valid to out_valid. There is a combinational path from out_ready to in_ready, by design.

Optional Feature:
- Macro: PIPE_ELASTIC_COUNT_EN.
- With the macro defined:
  - Adds a registered output count.
  - count <= count + (in_valid & in_ready) - (out_valid & out_ready) each clock.
  - count is forced to 0 on reset or flush.
  - Invariant: count equals the number of set v[i]; the range is 0..DEPTH.
- Without the macro: the count port and counter logic are absent, and the remaining behaviour is identical.

Test Plan:
- DW=8, DEPTH=3, out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_valid first rises after the 3rd edge following 0x11's accept; outputs 0x11,0x22,0x33 on 3 consecutive cycles; in_ready stays 1.
- out_ready=0, send 0xA0..0xA4 with in_valid=1 -> 0xA0,0xA1,0xA2 accepted; in_ready=0 from the cycle after 0xA2 is accepted. out_data=0xA0 held stable. Then out_ready=1 -> 0xA0,0xA1,0xA2,0xA3,0xA4 in order, nothing lost.
- Full pipe, in_valid=1 and out_ready=1 in the same cycle -> one accept and one emit; count stays 3 (COUNT_EN).
- Single word 0x5A inserted with gap cycles and out_ready=0 -> word advances to stage 2 and waits (bubble collapse). count=1.
- Two words stored, flush=1 for one cycle with in_valid=1 data 0x77 -> next cycle out_valid=0, count=0, 0x77 never appears.
- reset=1 asserted mid-stream for 2 cycles -> out_valid=0 and in_ready=0 during reset. After release, a new word 0x99 emerges after 3 cycles with no stale data.

Source files
------------

// File: rtl/pipe_elastic.sv
// rtl/pipe_elastic.sv - DEPTH-stage elastic valid/ready pipeline with bubble collapse (optional occupancy count under PIPE_ELASTIC_COUNT_EN)
module pipe_elastic #(
    parameter int DW    = 1,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
`ifdef PIPE_ELASTIC_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    logic [DEPTH-1:0] v;
    logic [DW-1:0]    d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_v;
    logic [DW-1:0]    src_d [DEPTH];
    logic             adv_run;

    // Advance chain: a stage may load when it is empty or everything downstream moves.
    always_comb begin
        adv     = '0;
        adv_run = out_ready | ~v[DEPTH-1];
        adv[DEPTH-1] = adv_run;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv_run = adv_run | ~v[i];
            adv[i]  = adv_run;
        end
    end

    // Source of each stage: upstream port for stage 0, previous stage otherwise.
    always_comb begin
        src_v    = '0;
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v[i-1];
            src_d[i] = d[i-1];
        end
    end

    assign in_ready  = adv[0] & ~flush & ~reset;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // Stage valids: cleared by reset or flush, otherwise follow the source when advancing.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v[i] <= src_v[i];
                end
            end
        end
    end

    // Stage data: no reset, loads only a valid word so empty slots keep old contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (adv[i] && src_v[i]) begin
                d[i] <= src_d[i];
            end
        end
    end

`ifdef PIPE_ELASTIC_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = v[DEPTH-1] & out_ready;

    // Occupancy counter tracks accepted minus emitted words.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_fire) - CW'(out_fire);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_elastic.sv
// tb/tb_pipe_elastic.sv - scoreboard bench for pipe_elastic with randomized and directed stimulus
module tb_pipe_elastic;

    localparam int DW    = 8;
    localparam int DEPTH = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
`ifdef PIPE_ELASTIC_COUNT_EN
    logic [$clog2(DEPTH+1)-1:0] count;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q [$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic          acc;

    pipe_elastic #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef PIPE_ELASTIC_COUNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the queue model at each falling edge.
    always @(negedge clk) begin
        logic          exp_rdy;
        logic [DW-1:0] e;
        exp_rdy = !reset && !flush && ((q.size() < DEPTH) || out_ready);
        if (stall_prev) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", {24'd0, out_data}, {24'd0, stall_data});
        end
        if (q.size() == 0) check("empty_valid", {31'd0, out_valid}, 32'd0);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
`ifdef PIPE_ELASTIC_COUNT_EN
        check("count", 32'(count), 32'(q.size()));
`endif
        if (out_valid === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
                check("pop_empty", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("out_data", {24'd0, out_data}, {24'd0, e});
            end
        end
        stall_prev = (out_valid === 1'b1) && !out_ready && !reset && !flush;
        stall_data = out_data;
        if (reset || flush) q.delete();
        else if (in_valid && exp_rdy) q.push_back(in_data);
    end

    // One clock of stimulus; acc reports whether the offered word was taken.
    task automatic cyc(input logic rst, input logic fl, input logic iv, input logic [DW-1:0] id, input logic ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #2;
        acc = iv & in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 8'h00, 0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);

        // Latency and throughput
        cyc(0, 0, 1, 8'h11, 1);
        cyc(0, 0, 1, 8'h22, 1);
        check("lat_early", {31'd0, out_valid}, 32'd0);
        cyc(0, 0, 1, 8'h33, 1);
        check("lat_first", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h11});
        cyc(0, 0, 0, 8'h00, 1);
        check("tput_2", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
        cyc(0, 0, 0, 8'h00, 1);
        check("tput_3", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h33});
        cyc(0, 0, 0, 8'h00, 1);

        // Fill while stalled, then drain with simultaneous accept/emit
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1, 8'hA0 + 8'(idx), 0);
            if (acc) idx++;
        end
        check("fill_accepted", idx, 3);
        check("fill_head", {24'd0, out_data}, 32'hA0);
        for (int k = 0; k < 10 && idx < 5; k++) begin
            cyc(0, 0, 1, 8'hA0 + 8'(idx), 1);
            if (acc) idx++;
        end
        check("drain_accepted", idx, 5);
        for (int k = 0; k < DEPTH + 2; k++) cyc(0, 0, 0, 8'h00, 1);

        // Single word with gaps collapses to the output stage
        cyc(0, 0, 1, 8'h5A, 0);
        for (int k = 0; k < DEPTH + 1; k++) cyc(0, 0, 0, 8'h00, 0);
        check("bubble_word", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h5A});
        cyc(0, 0, 0, 8'h00, 1);

        // Flush discards stored words and the offered word
        cyc(0, 0, 1, 8'h41, 0);
        cyc(0, 0, 1, 8'h42, 0);
        cyc(0, 1, 1, 8'h77, 0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < DEPTH + 2; k++) cyc(0, 0, 0, 8'h00, 1);
        check("flush_no_77", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream
        cyc(0, 0, 1, 8'h51, 0);
        cyc(0, 0, 1, 8'h52, 0);
        cyc(1, 0, 1, 8'h53, 1);
        check("rst1_valid", {30'd0, out_valid, in_ready}, 32'd0);
        cyc(1, 0, 1, 8'h54, 1);
        check("rst2_valid", {30'd0, out_valid, in_ready}, 32'd0);
        cyc(0, 0, 1, 8'h99, 1);
        cyc(0, 0, 0, 8'h00, 1);
        check("rst_new_early", {31'd0, out_valid}, 32'd0);
        cyc(0, 0, 0, 8'h00, 1);
        check("rst_new_word", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h99});
        cyc(0, 0, 0, 8'h00, 1);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) == 0),
                $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 7);
        end
        for (int k = 0; k < DEPTH + 2; k++) cyc(0, 0, 0, 8'h00, 1);
        check("final_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
